// File: rtl/fdivsqrt_digitgen2.sv
// fdivsqrt_digitgen2: radix-2 restoring-free division digit generator with OTFC position mask
module fdivsqrt_digitgen2 #(
    parameter int DIVB = 12
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    input  logic            flush,
    input  logic [DIVB:0]   X,
    input  logic [DIVB:0]   D,
    output logic            ready,
    output logic            digit_valid,
    output logic            up,
    output logic            un,
    output logic [DIVB+1:0] C,
    output logic            done,
    output logic            rem_neg,
    output logic            rem_zero
);
    localparam int CW = $clog2(DIVB + 1);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t          state, state_n;
    logic [DIVB+3:0] w, w2, w_n, dd;
    logic [DIVB:0]   dreg;
    logic [DIVB+1:0] c;
    logic [CW-1:0]   cnt;
    logic [3:0]      e;
    logic            up_i, un_i, accept, last;
    always_comb begin
        // |W| < 2 so bits DIVB+3 and DIVB+2 agree; either serves as the sign of 2W
        e       = {w[DIVB+3], w[DIVB+1:DIVB-1]};
        up_i    = ~e[3];
        un_i    = e[3] & (e != 4'b1111);
        w2      = {w[DIVB+2:0], 1'b0};
        dd      = {2'b00, dreg, 1'b0};
        w_n     = up_i ? w2 - dd : un_i ? w2 + dd : w2;
        ready   = state != BUSY;
        digit_valid = state == BUSY;
        up      = digit_valid & up_i;
        un      = digit_valid & un_i;
        C       = digit_valid ? c : '0;
        done    = state == DONE;
        last    = cnt == CW'(DIVB);
        accept  = ready & start & ~flush;
        state_n = flush ? IDLE : accept ? BUSY : (state == BUSY) ? (last ? DONE : BUSY) : IDLE;
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            w        <= '0;
            dreg     <= '0;
            c        <= '0;
            cnt      <= '0;
            rem_neg  <= 1'b0;
            rem_zero <= 1'b0;
        end else begin
            state <= state_n;
            if (accept) begin
                w        <= {3'b000, X};
                dreg     <= D;
                c        <= {2'b11, {DIVB{1'b0}}};
                cnt      <= '0;
                rem_neg  <= 1'b0;
                rem_zero <= 1'b0;
            end else if (digit_valid && !flush) begin
                w   <= w_n;
                c   <= {c[DIVB+1], c[DIVB+1:1]};
                cnt <= cnt + 1'b1;
                if (last) begin
                    rem_neg  <= w_n[DIVB+3];
                    rem_zero <= w_n == '0;
                end
            end
        end
    end
endmodule
